// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide sequencer.
// State encodings, opcode values and the iteration count.
package muldiv_pkg;
    // FSM state encoding
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] FIX   = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITERATIONS = 32;
endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation.
// Used to form operand magnitudes and to restore result signs.
module muldiv_signfix #(
    parameter int W = 33
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply / restoring divide owning the HI/LO result path.
// Works on operand magnitudes; signs are reapplied in a single FIX cycle.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hi_write,
    output logic             lo_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITERATIONS);

    logic [2:0]         state;
    logic [CW-1:0]      count;
    logic               opReg, signA, signB;
    logic [WIDTH:0]     magA, magB, absA, absB;
    logic [2*WIDTH-1:0] work, multNext, divNext, prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;

    logic [WIDTH:0]     addSum;
    logic [WIDTH-1:0]   diff;
    logic               geq;

    // 0x80000000 needs the extra bit to hold its magnitude of 2^31
    muldiv_signfix #(.W(WIDTH+1)) uAbsA (.neg(a[WIDTH-1]), .x({a[WIDTH-1], a}), .y(absA));
    muldiv_signfix #(.W(WIDTH+1)) uAbsB (.neg(b[WIDTH-1]), .x({b[WIDTH-1], b}), .y(absB));

    muldiv_signfix #(.W(2*WIDTH)) uFixProd (.neg(signA ^ signB), .x(work), .y(prodFix));
    muldiv_signfix #(.W(WIDTH)) uFixQuot (.neg(signA ^ signB), .x(work[WIDTH-1:0]), .y(quotFix));
    muldiv_signfix #(.W(WIDTH)) uFixRem (.neg(signA), .x(work[2*WIDTH-1:WIDTH]), .y(remFix));

    // Multiply: work = {acc, multiplier}; add on LSB then shift right
    always_comb begin
        addSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? magA : '0);
        multNext = {addSum, work[WIDTH-1:1]};
    end

    // Divide: work = {remainder, dividend/quotient}; shift left, trial subtract
    always_comb begin
        geq  = work[2*WIDTH-1:WIDTH-1] >= magB;
        diff = work[2*WIDTH-2:WIDTH-1] - magB[WIDTH-1:0];
        divNext = geq ? {diff, work[WIDTH-2:0], 1'b1} : {work[2*WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            opReg <= OP_MULT;
            signA <= 1'b0;
            signB <= 1'b0;
            magA  <= '0;
            magB  <= '0;
            work  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opReg <= op;
                    signA <= a[WIDTH-1];
                    signB <= b[WIDTH-1];
                    magA  <= absA;
                    magB  <= absB;
                    count <= '0;
                    work  <= {{WIDTH{1'b0}}, (op == OP_DIV) ? absA[WIDTH-1:0] : absB[WIDTH-1:0]};
                    state <= (op == OP_DIV && b == '0) ? FAULT : RUN;
                end
                RUN: begin
                    work  <= (opReg == OP_DIV) ? divNext : multNext;
                    count <= count + 1'b1;
                    if (count == CW'(ITERATIONS - 1)) state <= FIX;
                end
                FIX: begin
                    if (opReg == OP_DIV) begin
                        hi <= remFix;
                        lo <= quotFix;
                    end else begin
                        {hi, lo} <= prodFix;
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign hi_write = state == DONE;
    assign lo_write = state == DONE;
    assign div_zero = state == FAULT;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized checks of muldiv_sequencer against a
// plain-arithmetic signed multiply/divide reference.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero, hi_write, lo_write;
    logic [31:0] hi, lo;

    int nChecks = 0;
    int nPass = 0;

    logic [31:0] edgeVals [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi_write(hi_write), .lo_write(lo_write), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: 64-bit signed arithmetic; SV '/' truncates toward zero and
    // '%' takes the dividend's sign, matching the required semantics.
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 1'b0) begin
            r  = sx * sy;
            eh = r[63:32];
            el = r[31:0];
        end else begin
            r  = sx / sy;
            el = r[31:0];
            r  = sx % sy;
            eh = r[31:0];
        end
    endfunction

    // Returns at the first negedge after the sampling edge (cycle 1), with
    // inputs scrambled to show they are not re-sampled.
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    endtask

    task automatic waitEvent(inout int cyc);
        while (!(done || div_zero) && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic runOp(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        int cyc;
        model(o, x, y, eh, el);
        launch(o, x, y);
        cyc = 1;
        chk({tag, " busy"}, 64'(busy), 64'(1));
        waitEvent(cyc);
        chk({tag, " latency"}, 64'(cyc), 64'(34));
        chk({tag, " strobes"}, 64'({done, hi_write, lo_write, div_zero}), 64'(4'b1110));
        chk({tag, " hilo"}, {hi, lo}, {eh, el});
        @(negedge clk);
        chk({tag, " after"}, 64'({busy, done, hi_write, lo_write}), 64'(0));
    endtask

    initial begin
        int cyc, nd;
        logic o;
        logic [31:0] x, y;

        repeat (3) @(negedge clk);
        chk("reset flags", 64'({busy, done, div_zero, hi_write, lo_write}), 64'(0));
        chk("reset hilo", {hi, lo}, 64'(0));
        reset = 1'b0;

        runOp("mul7xm3", 1'b0, 32'd7, 32'hFFFFFFFD);
        chk("mul7xm3 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        // divide by zero
        launch(1'b1, 32'd5, 32'd0);
        chk("dz pulse", 64'({div_zero, done, hi_write, lo_write, busy}), 64'(5'b10001));
        @(negedge clk);
        chk("dz idle", 64'({busy, div_zero}), 64'(0));
        nd = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || hi_write || lo_write || div_zero || busy) nd++;
        end
        chk("dz quiet", 64'(nd), 64'(0));
        chk("dz hilo kept", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        runOp("divm7by2", 1'b1, 32'hFFFFFFF9, 32'd2);
        chk("divm7by2 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        runOp("div7bym2", 1'b1, 32'd7, 32'hFFFFFFFE);
        chk("div7bym2 const", {hi, lo}, 64'h00000001_FFFFFFFD);
        runOp("divovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf const", {hi, lo}, 64'h00000000_80000000);
        runOp("mulovf", 1'b0, 32'h80000000, 32'h80000000);
        chk("mulovf const", {hi, lo}, 64'h40000000_00000000);

        // start re-pulsed mid-run, then held across DONE
        launch(1'b0, 32'd3, 32'd4);
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd0;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        waitEvent(cyc);
        chk("repulse latency", 64'(cyc), 64'(34));
        chk("repulse strobes", 64'({done, div_zero}), 64'(2'b10));
        chk("repulse hilo", {hi, lo}, 64'h00000000_0000000C);
        start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("held start c1", 64'(busy), 64'(0));
        @(negedge clk);
        chk("held start c2", 64'(busy), 64'(0));
        chk("held start hilo", {hi, lo}, 64'h00000000_0000000C);

        // reset in flight
        launch(1'b0, 32'd5, 32'd6);
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset busy", 64'(busy), 64'(0));
        chk("midreset hilo", {hi, lo}, 64'(0));
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || hi_write || lo_write || div_zero) nd++;
        end
        chk("midreset no done", 64'(nd), 64'(0));
        runOp("mul2x2", 1'b0, 32'd2, 32'd2);
        chk("mul2x2 lo", 64'(lo), 64'(4));

        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(16, 30);
            if (o && y == 32'd0) y = 32'd3;
            runOp($sformatf("rnd%0d", i), o, x, y);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
